// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - parametrised 1W/2R register file with bypass, zero reg and clear sweep
module param_register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG0  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    output logic                  o_busy,
    input  logic                  i_write_enable,
    input  logic [ADDR_WIDTH-1:0] i_write_address,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    output logic                  o_write_accepted,
    input  logic [ADDR_WIDTH-1:0] i_address_a,
    output logic [DATA_WIDTH-1:0] o_read_data_a,
    input  logic [ADDR_WIDTH-1:0] i_address_b,
    output logic [DATA_WIDTH-1:0] o_read_data_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT_SWEEP  = 2'd0,
        S_IDLE        = 2'd1,
        S_CLEAR_SWEEP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_count;
    logic [ADDR_WIDTH-1:0]   w_next_count;

    // Array has no reset so it can map onto distributed RAM; the sweep zeroes it instead.
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_busy;
    logic                    w_write_accepted;
    logic                    w_write_commit;
    logic                    w_sweeping;

    assign w_sweeping       = (r_state == S_INIT_SWEEP) || (r_state == S_CLEAR_SWEEP);
    assign w_busy           = (r_state != S_IDLE);
    assign w_write_accepted = i_write_enable & ~w_busy;
    // A write to register 0 is still acknowledged when it is hardwired, it just never lands.
    assign w_write_commit   = w_write_accepted &
                              ~((ZERO_REG0 != 0) && (i_write_address == '0));

    assign o_busy           = w_busy;
    assign o_write_accepted = w_write_accepted;

    // State and sweep counter register; reset restarts the power-on sweep from address 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_INIT_SWEEP;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    // Next-state logic: sweeps run DEPTH edges, Clear is only honoured from IDLE.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            S_INIT_SWEEP, S_CLEAR_SWEEP: begin
                if (r_count == LAST_ADDR) begin
                    w_next_state = S_IDLE;
                    w_next_count = '0;
                end else begin
                    w_next_count = r_count + ADDR_WIDTH'(1);
                end
            end
            S_IDLE: begin
                if (i_clear) begin
                    w_next_state = S_CLEAR_SWEEP;
                    w_next_count = '0;
                end
            end
            default: begin
                w_next_state = S_INIT_SWEEP;
                w_next_count = '0;
            end
        endcase
    end

    // Array write: sweep zeroing has the port while busy, otherwise accepted writes land.
    always_ff @(posedge i_clk) begin
        if (w_sweeping) begin
            r_mem[r_count] <= '0;
        end else if (w_write_commit) begin
            r_mem[i_write_address] <= i_write_data;
        end
    end

    // Read port A: busy masks everything, then hardwired zero, then bypass, then array.
    always_comb begin
        o_read_data_a = r_mem[i_address_a];
        if ((BYPASS != 0) && w_write_accepted && (i_address_a == i_write_address)) begin
            o_read_data_a = i_write_data;
        end
        if ((ZERO_REG0 != 0) && (i_address_a == '0)) begin
            o_read_data_a = '0;
        end
        if (w_busy) begin
            o_read_data_a = '0;
        end
    end

    // Read port B: same priority as port A, resolved independently.
    always_comb begin
        o_read_data_b = r_mem[i_address_b];
        if ((BYPASS != 0) && w_write_accepted && (i_address_b == i_write_address)) begin
            o_read_data_b = i_write_data;
        end
        if ((ZERO_REG0 != 0) && (i_address_b == '0)) begin
            o_read_data_b = '0;
        end
        if (w_busy) begin
            o_read_data_b = '0;
        end
    end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised next-generation register file for the CPU datapath.
- One synchronous write port and two asynchronous read ports; data width and depth are configurable.
- Adds optional same-cycle write-to-read bypass, an optional hardwired-zero register 0, and a sequential clear engine.
- The clear engine zeroes the array after reset or on command; the array itself carries no reset, so it maps to distributed RAM.

Parameters:
- DATA_WIDTH, 16, bits per register.
- ADDR_WIDTH, 6, address bits; DEPTH = 2**ADDR_WIDTH registers (derived, not overridable).
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to that read port.
- ZERO_REG0, 0, when 1 register 0 always reads 0 and writes to it are discarded.

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Clear  in  1  synchronous request to zero every register.
- Busy  out  1  high while the clear engine is sweeping.
- WriteEnable  in  1  write request.
- WriteAddress  in  ADDR_WIDTH  register to write.
- WriteData  in  DATA_WIDTH  value to write.
- WriteAccepted  out  1  combinational: WriteEnable & ~Busy.
- AddressA  in  ADDR_WIDTH  read port A address.
- ReadDataA  out  DATA_WIDTH  asynchronous read data, port A.
- AddressB  in  ADDR_WIDTH  read port B address.
- ReadDataB  out  DATA_WIDTH  asynchronous read data, port B.

Behaviour:
- Reset is asynchronous, active-low, and is the one decided requirement. Assertion forces FSM to INIT_SWEEP, sweep counter to 0, Busy=1. The array is not reset.
- FSM states: INIT_SWEEP, IDLE, CLEAR_SWEEP. Busy=1 in both sweep states.
- Sweep operation:
  - Each rising edge in a sweep state writes 0 to Registers[counter] and increments counter.
  - On the edge where counter==DEPTH-1, go to IDLE and reset counter to 0.
  - A sweep therefore lasts exactly DEPTH edges; Busy falls after the DEPTH-th edge following reset release or sweep entry.
- IDLE with Clear=1: next edge enters CLEAR_SWEEP with counter=0. Clear is ignored while Busy=1; it neither restarts nor extends a sweep.
- Reset asserted mid-sweep: async return to INIT_SWEEP with counter=0. The full sweep restarts after release.
- Writes:
  - If WriteEnable & ~Busy, Registers[WriteAddress] <= WriteData on the rising edge. WriteAccepted reflects this combinationally.
  - While Busy=1, writes are dropped (WriteAccepted=0).
  - If ZERO_REG0=1 and WriteAddress==0, the write is discarded, but WriteAccepted still =1.
  - A write accepted in the same IDLE cycle as Clear=1 lands, then is zeroed by the sweep.
- Reads, combinational, with priority highest first:
  - Busy=1 → 0.
  - ZERO_REG0=1 and address==0 → 0.
  - BYPASS=1, WriteAccepted=1 and address==WriteAddress → WriteData.
  - Otherwise Registers[address].
- Both ports may read the same address, and the write address, simultaneously; each port resolves independently.
- Outputs after reset: Busy=1, WriteAccepted=0, ReadDataA=ReadDataB=0.
- Widths: no arithmetic on data. The sweep counter is ADDR_WIDTH bits; the terminal compare is against DEPTH-1, with no wrap-through.

Test Plan:
- Reset, defaults (16/6): release ResetN -> Busy=1 for exactly 64 edges, ReadDataA/B=0 throughout. Then read every address -> 0x0000.
- Write then read: after sweep, write 0xBEEF to addr 5, next cycle AddressA=5, AddressB=5 -> both 0xBEEF. Write 0x1234 to addr 63 -> reads 0x1234, no aliasing to addr 0.
- Bypass: BYPASS=1, WriteEnable=1, WriteAddress=9, WriteData=0xA5A5, AddressA=9 same cycle -> ReadDataA=0xA5A5 before the edge. With BYPASS=0 -> ReadDataA=old value, 0xA5A5 only after the edge.
- Clear command: fill addrs 0..63, pulse Clear one cycle together with write 0x7777 to addr 3 -> Busy high 64 edges, write attempts during sweep give WriteAccepted=0. Afterwards all reads 0, including addr 3.
- Reset mid-sweep: assert ResetN=0 at sweep edge 20 -> Busy stays 1. After release, Busy lasts 64 further edges. A Clear pulse during sweep does not extend it.
- ZERO_REG0=1: write 0xFFFF to addr 0 -> WriteAccepted=1, ReadDataA(addr 0)=0 both same cycle and later. Addr 1 behaves normally.
